// File: rtl/vga_timing_pkg.sv
// Shared timing constants, FSM state encoding and helpers for the VGA timing
// controller and its per-axis counters.
package vga_timing_pkg;

    // Coordinate width; both axis totals must fit (<= 1024).
    localparam int unsigned COORD_W = 10;

    // Default 640x480@60 timing (pixels / lines).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_e;

    // Total period of one axis: ACTIVE, FP, SYNC, BP phases back to back.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total();
        return axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    endfunction

    function automatic int unsigned v_total();
        return axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Next-count logic and phase decode for one timing axis.
// Ports:
//   cnt        current count (held in the parent's output register)
//   step       advance by one this cycle
//   clear      force the next count to 0 (wins over step)
//   cnt_next_c next count, wraps TOTAL-1 -> 0
//   wrap_c     this step wraps the axis
//   in_active_c / in_sync_c  phase decode of the next count, so registered
//              outputs line up with the registered count
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic [COORD_W-1:0] cnt,
    input  logic               step,
    input  logic               clear,
    output logic [COORD_W-1:0] cnt_next_c,
    output logic               wrap_c,
    output logic               in_active_c,
    output logic               in_sync_c
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACTIVE_END = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    logic is_last;

    // Count sequencing and decode of the resulting position.
    always_comb begin
        is_last    = (cnt == LAST);
        wrap_c     = 1'b0;
        cnt_next_c = cnt;
        if (clear) begin
            cnt_next_c = '0;
        end else if (step) begin
            wrap_c     = is_last;
            cnt_next_c = is_last ? '0 : cnt + COORD_W'(1);
        end
        in_active_c = (cnt_next_c < ACTIVE_END);
        in_sync_c   = (cnt_next_c >= SYNC_START) && (cnt_next_c < SYNC_END);
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Frame-level VGA timing controller: run/drain FSM, h/v position counters and
// registered sync / display-enable / strobe outputs, all aligned to x/y.
// Ports:
//   clk_25, reset_n (synchronous, active-low), en (run request)
//   h_sync, v_sync   sync outputs, asserted level SYNC_POL
//   de               display enable for visible pixels
//   x, y             current horizontal / vertical count
//   line_start       pulse at x==0 while running
//   frame_start      pulse at x==0, y==0 while running
//   vblank           running and y in vertical blanking
//   running          controller in RUN or DRAIN
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic               clk_25,
    input  logic               reset_n,
    input  logic               en,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic               running
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    vga_state_e state_q, state_d;

    logic               run_q, run_d;
    logic               frame_end;
    logic [COORD_W-1:0] h_next, v_next;
    logic               h_wrap, h_in_active, h_in_sync;
    logic               v_wrap_unused, v_in_active, v_in_sync;

    assign run_q     = (state_q != IDLE);
    assign run_d     = (state_d != IDLE);
    assign frame_end = run_q && (x == H_LAST) && (y == V_LAST);

    // Next-state logic; DRAIN only leaves for IDLE on the last pixel of a frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (frame_end)  state_d = IDLE;
                else if (en)    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters are cleared whenever the next state is IDLE so stop lands on (0,0).
    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .cnt         (x),
        .step        (run_q),
        .clear       (!run_d),
        .cnt_next_c  (h_next),
        .wrap_c      (h_wrap),
        .in_active_c (h_in_active),
        .in_sync_c   (h_in_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .cnt         (y),
        .step        (h_wrap),
        .clear       (!run_d),
        .cnt_next_c  (v_next),
        .wrap_c      (v_wrap_unused),
        .in_active_c (v_in_active),
        .in_sync_c   (v_in_sync)
    );

    // State and output registers, all loaded from the next position.
    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x           <= '0;
            y           <= '0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            running     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x           <= h_next;
            y           <= v_next;
            h_sync      <= (run_d && h_in_sync) ? SYNC_POL : ~SYNC_POL;
            v_sync      <= (run_d && v_in_sync) ? SYNC_POL : ~SYNC_POL;
            de          <= run_d && h_in_active && v_in_active;
            line_start  <= run_d && (h_next == '0);
            frame_start <= run_d && (h_next == '0) && (v_next == '0);
            vblank      <= run_d && !v_in_active;
            running     <= run_d;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: one default 640x480 instance for line-level timing and one
// reduced-geometry instance (30x19 totals) for frame-level behaviour.
module tb_vga_timing_ctrl;

    logic clk;
    logic reset_n;
    logic en;

    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vb, d_run;
    logic [9:0] d_x, d_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vb, s_run;
    logic [9:0] s_x, s_y;

    int vectors    = 0;
    int miscompares = 0;

    vga_timing_ctrl u_dflt (
        .clk_25      (clk),
        .reset_n     (reset_n),
        .en          (en),
        .h_sync      (d_hs),
        .v_sync      (d_vs),
        .de          (d_de),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .vblank      (d_vb),
        .running     (d_run)
    );

    // Small geometry: H 16+4+6+4 = 30 (sync 20..25), V 12+2+2+3 = 19 (sync 14..15).
    vga_timing_ctrl #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b0)
    ) u_small (
        .clk_25      (clk),
        .reset_n     (reset_n),
        .en          (en),
        .h_sync      (s_hs),
        .v_sync      (s_vs),
        .de          (s_de),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .vblank      (s_vb),
        .running     (s_run)
    );

    wire [26:0] d_act = {d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_vb, d_run};
    wire [26:0] s_act = {s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_vb, s_run};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {x,y,h_sync,v_sync,de,line_start,frame_start,vblank,running}.
    function automatic logic [26:0] exp_vec(input int h, input int v, input bit run,
                                            input int ha, input int hfp, input int hsw,
                                            input int va, input int vfp, input int vsw);
        logic hs, vs, de, ls, fs, vb;
        hs = !(run && h >= ha + hfp && h < ha + hfp + hsw);
        vs = !(run && v >= va + vfp && v < va + vfp + vsw);
        de = run && h < ha && v < va;
        ls = run && h == 0;
        fs = run && h == 0 && v == 0;
        vb = run && v >= va;
        return {10'(h), 10'(v), hs, vs, de, ls, fs, vb, run};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with en high; returns sampled on the first running cycle.
    task automatic restart();
        reset_n = 1'b0;
        en      = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [26:0] e;
        reset_n = 1'b0;
        en      = 1'b1;
        repeat (3) step();
        e = exp_vec(0, 0, 1'b0, 640, 16, 96, 480, 10, 2);
        vectors++;
        if (d_act !== e) begin
            miscompares++;
            $display("FAIL reset_dflt got=%h exp=%h", d_act, e);
        end
        e = exp_vec(0, 0, 1'b0, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL reset_small got=%h exp=%h", s_act, e);
        end
        reset_n = 1'b1;
        step();
        e = exp_vec(0, 0, 1'b1, 640, 16, 96, 480, 10, 2);
        vectors++;
        if (d_act !== e) begin
            miscompares++;
            $display("FAIL start_dflt got=%h exp=%h", d_act, e);
        end
        e = exp_vec(0, 0, 1'b1, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL start_small got=%h exp=%h", s_act, e);
        end
    endtask

    task automatic test_line();
        logic [26:0] e;
        int hs_low = 0;
        restart();
        for (int c = 0; c <= 800; c++) begin
            e = exp_vec(c % 800, c / 800, 1'b1, 640, 16, 96, 480, 10, 2);
            vectors++;
            if (d_act !== e) begin
                miscompares++;
                $display("FAIL line c=%0d got=%h exp=%h", c, d_act, e);
            end
            if (c < 800 && d_hs === 1'b0) hs_low++;
            step();
        end
        vectors++;
        if (hs_low !== 96) begin
            miscompares++;
            $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
    endtask

    task automatic test_frame();
        logic [26:0] e;
        int vs_low = 0;
        int fs_cnt = 0;
        restart();
        for (int n = 0; n <= 570; n++) begin
            e = exp_vec(n % 30, (n / 30) % 19, 1'b1, 16, 4, 6, 12, 2, 2);
            vectors++;
            if (s_act !== e) begin
                miscompares++;
                $display("FAIL frame n=%0d got=%h exp=%h", n, s_act, e);
            end
            if (n < 570 && s_vs === 1'b0) vs_low++;
            if (s_fs === 1'b1) fs_cnt++;
            step();
        end
        vectors++;
        if (vs_low !== 60) begin
            miscompares++;
            $display("FAIL vsync_width got=%0d exp=60", vs_low);
        end
        vectors++;
        if (fs_cnt !== 2) begin
            miscompares++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        end
    endtask

    task automatic test_drain_resume();
        logic [26:0] e;
        restart();
        for (int n = 0; n <= 600; n++) begin
            if (n == 4 * 30)  en = 1'b0;
            if (n == 10 * 30) en = 1'b1;
            e = exp_vec(n % 30, (n / 30) % 19, 1'b1, 16, 4, 6, 12, 2, 2);
            vectors++;
            if (s_act !== e) begin
                miscompares++;
                $display("FAIL resume n=%0d got=%h exp=%h", n, s_act, e);
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic [26:0] e;
        restart();
        for (int n = 0; n < 570; n++) begin
            if (n == 50) en = 1'b0;
            e = exp_vec(n % 30, n / 30, 1'b1, 16, 4, 6, 12, 2, 2);
            vectors++;
            if (s_act !== e) begin
                miscompares++;
                $display("FAIL drain n=%0d got=%h exp=%h", n, s_act, e);
            end
            step();
        end
        e = exp_vec(0, 0, 1'b0, 16, 4, 6, 12, 2, 2);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (s_act !== e) begin
                miscompares++;
                $display("FAIL idle i=%0d got=%h exp=%h", i, s_act, e);
            end
            step();
        end
        en = 1'b1;
        step();
        e = exp_vec(0, 0, 1'b1, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL restart got=%h exp=%h", s_act, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] e;
        restart();
        repeat (10 * 30 + 15) step();
        e = exp_vec(15, 10, 1'b1, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL mid_pos got=%h exp=%h", s_act, e);
        end
        reset_n = 1'b0;
        step();
        e = exp_vec(0, 0, 1'b0, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL mid_reset_small got=%h exp=%h", s_act, e);
        end
        e = exp_vec(0, 0, 1'b0, 640, 16, 96, 480, 10, 2);
        vectors++;
        if (d_act !== e) begin
            miscompares++;
            $display("FAIL mid_reset_dflt got=%h exp=%h", d_act, e);
        end
        reset_n = 1'b1;
        step();
        e = exp_vec(0, 0, 1'b1, 16, 4, 6, 12, 2, 2);
        vectors++;
        if (s_act !== e) begin
            miscompares++;
            $display("FAIL mid_restart got=%h exp=%h", s_act, e);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_drain_resume();
        test_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
